// File: rtl/swg_window_reassembler_if.sv
// Valid/ready stream channel used on both sides of the window reassembler.
interface swg_window_reassembler_if #(
  parameter int W = 8
) ();
  logic         TVALID;
  logic         TREADY;
  logic [W-1:0] TDATA;

  modport master (output TVALID, output TDATA, input TREADY);
  modport slave  (input TVALID, input TDATA, output TREADY);
endinterface

// File: rtl/swg_window_reassembler.sv
// Rebuilds a raster-order feature map from a stride-1 K_H x K_W window stream.
// A full frame is written into a buffer, then drained sequentially through a 2-entry queue.
module swg_window_reassembler #(
  parameter int    BIT_WIDTH = 8,
  parameter int    SIMD      = 1,
  parameter int    IFM_CH    = 1,
  parameter int    IFM_H     = 30,
  parameter int    IFM_W     = 30,
  parameter int    K_H       = 3,
  parameter int    K_W       = 3,
  parameter string RAM_STYLE = "distributed"
) (
  input logic                      ap_clk,
  input logic                      ap_rst_n,
  swg_window_reassembler_if.slave  in0_V_V,
  swg_window_reassembler_if.master out_V_V
);

  localparam int W     = BIT_WIDTH * SIMD;
  localparam int CF    = IFM_CH / SIMD;
  localparam int OH    = IFM_H - K_H + 1;
  localparam int OW    = IFM_W - K_W + 1;
  localparam int DEPTH = IFM_H * IFM_W * CF;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CFW   = (CF  > 1) ? $clog2(CF)  : 1;
  localparam int KWW   = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int KHW   = (K_H > 1) ? $clog2(K_H) : 1;
  localparam int OWW   = (OW  > 1) ? $clog2(OW)  : 1;
  localparam int OHW   = (OH  > 1) ? $clog2(OH)  : 1;

  // Address deltas when the kernel row wraps, the window slides right, or drops a row.
  localparam logic [AW-1:0] STEP_ROW  = AW'((IFM_W - K_W) * CF + 1);
  localparam logic [AW-1:0] STEP_OW   = AW'(CF);
  localparam logic [AW-1:0] STEP_OH   = AW'(K_W * CF);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state;
  logic            in_rdy;
  logic [CFW-1:0]  cf;
  logic [KWW-1:0]  kw;
  logic [KHW-1:0]  kh;
  logic [OWW-1:0]  ow;
  logic [OHW-1:0]  oh;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   win_base;
  logic            cf_last, kw_last, kh_last, ow_last, oh_last;
  logic            in_fire;

  logic [AW-1:0]   rd_addr;
  logic            rd_all;
  logic            rd_vld_p0;
  logic            rd_last_p0;
  logic            rd_vld_p1;
  logic            rd_last_p1;
  logic [W-1:0]    rd_data_p1;

  logic [1:0]      q_cnt;
  logic [1:0]      occ;
  logic [W-1:0]    q_data0, q_data1;
  logic            q_last0, q_last1;
  logic            out_vld;
  logic            push, pop;
  logic            drain_done;

  assign cf_last = (cf == CFW'(CF - 1));
  assign kw_last = (kw == KWW'(K_W - 1));
  assign kh_last = (kh == KHW'(K_H - 1));
  assign ow_last = (ow == OWW'(OW - 1));
  assign oh_last = (oh == OHW'(OH - 1));
  assign in_fire = in0_V_V.TVALID & in_rdy;

  assign out_vld    = (q_cnt != 2'd0);
  assign push       = rd_vld_p1;
  assign pop        = out_vld & out_V_V.TREADY;
  assign drain_done = pop & q_last0;

  // A read is issued only if its result is guaranteed a queue slot one cycle later.
  assign occ        = q_cnt + {1'b0, rd_vld_p1};
  assign rd_vld_p0  = (state == DRAIN) && !rd_all && ((occ < 2'd2) || pop);
  assign rd_last_p0 = (rd_addr == LAST_ADDR);

  assign in0_V_V.TREADY = in_rdy;
  assign out_V_V.TVALID = out_vld;
  assign out_V_V.TDATA  = q_data0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= FILL;
      in_rdy    <= 1'b0;
      cf        <= '0;
      kw        <= '0;
      kh        <= '0;
      ow        <= '0;
      oh        <= '0;
      wr_addr   <= '0;
      win_base  <= '0;
      rd_addr   <= '0;
      rd_all    <= 1'b0;
      rd_vld_p1 <= 1'b0;
      q_cnt     <= 2'd0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      q_cnt     <= q_cnt + {1'b0, push} - {1'b0, pop};
      case (state)
        FILL: begin
          in_rdy <= 1'b1;
          if (in_fire) begin
            if (!cf_last) begin
              cf      <= cf + CFW'(1);
              wr_addr <= wr_addr + AW'(1);
            end else begin
              cf <= '0;
              if (!kw_last) begin
                kw      <= kw + KWW'(1);
                wr_addr <= wr_addr + AW'(1);
              end else begin
                kw <= '0;
                if (!kh_last) begin
                  kh      <= kh + KHW'(1);
                  wr_addr <= wr_addr + STEP_ROW;
                end else begin
                  kh <= '0;
                  if (!ow_last) begin
                    ow       <= ow + OWW'(1);
                    win_base <= win_base + STEP_OW;
                    wr_addr  <= win_base + STEP_OW;
                  end else begin
                    ow <= '0;
                    if (!oh_last) begin
                      oh       <= oh + OHW'(1);
                      win_base <= win_base + STEP_OH;
                      wr_addr  <= win_base + STEP_OH;
                    end else begin
                      oh       <= '0;
                      win_base <= '0;
                      wr_addr  <= '0;
                      state    <= DRAIN;
                      in_rdy   <= 1'b0;
                    end
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          in_rdy <= 1'b0;
          if (rd_vld_p0) begin
            rd_addr <= rd_last_p0 ? '0 : rd_addr + AW'(1);
            if (rd_last_p0) rd_all <= 1'b1;
          end
          if (drain_done) begin
            state  <= FILL;
            rd_all <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // ---- stage p0 -> p1: frame buffer write port and registered read port ----
  if (RAM_STYLE == "block") begin : g_bram
    (* ram_style = "block" *) logic [W-1:0] mem [DEPTH];
    always_ff @(posedge ap_clk) begin
      if (in_fire)   mem[wr_addr] <= in0_V_V.TDATA;
      if (rd_vld_p0) rd_data_p1   <= mem[rd_addr];
    end
  end else begin : g_lutram
    (* ram_style = "distributed" *) logic [W-1:0] mem [DEPTH];
    always_ff @(posedge ap_clk) begin
      if (in_fire)   mem[wr_addr] <= in0_V_V.TDATA;
      if (rd_vld_p0) rd_data_p1   <= mem[rd_addr];
    end
  end

  // ---- stage p1 -> output queue: two entries, head drives the output ----
  always_ff @(posedge ap_clk) begin
    if (rd_vld_p0) rd_last_p1 <= rd_last_p0;
    if (push && pop) begin
      if (q_cnt == 2'd1) begin
        q_data0 <= rd_data_p1;
        q_last0 <= rd_last_p1;
      end else begin
        q_data0 <= q_data1;
        q_last0 <= q_last1;
        q_data1 <= rd_data_p1;
        q_last1 <= rd_last_p1;
      end
    end else if (push) begin
      if (q_cnt == 2'd0) begin
        q_data0 <= rd_data_p1;
        q_last0 <= rd_last_p1;
      end else begin
        q_data1 <= rd_data_p1;
        q_last1 <= rd_last_p1;
      end
    end else if (pop) begin
      q_data0 <= q_data1;
      q_last0 <= q_last1;
    end
  end

endmodule
